// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, issues single-outstanding word fetches over a valid/ready
// request channel and accepts responses unconditionally. Decode stalls are
// absorbed by a one-entry skid buffer; redirects flush IF/ID and discard any
// response still in flight.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetch_cnt / perf_drop_cnt.
module fetch_stage #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;

  logic            buf_valid;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;

  logic            handshake;
  logic            rsp_take;
  logic            rsp_drop;
  logic [XLEN-1:0] redirect_target;

  // Request is held off while the skid buffer is occupied so it cannot overflow.
  assign imem_req_valid  = rst_n && (state == S_REQ) && !buf_valid;
  assign imem_req_addr   = pc;
  assign handshake       = imem_req_valid && imem_req_ready;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // A response is kept only in S_WAIT when no redirect arrives with it.
  assign rsp_take = imem_rsp_valid && (state == S_WAIT) && !redirect_valid;
  assign rsp_drop = imem_rsp_valid &&
                    ((state == S_DROP) || ((state == S_WAIT) && redirect_valid));

  assign id_opcode = id_instr[6:0];

  // Fetch FSM, program counter and address of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            req_pc <= pc;
            state  <= redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid)      state <= S_REQ;
          else if (redirect_valid) state <= S_DROP;
        end
        S_DROP: begin
          // Outstanding request finishes here even if another redirect lands now.
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase

      if (redirect_valid) pc <= redirect_target;
      else if (handshake) pc <= pc + XLEN'(4);
    end
  end

  // IF/ID register and skid buffer: redirect flush, delivery, consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid  <= 1'b0;
      id_instr  <= NOP_INSTR;
      id_pc     <= '0;
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else if (redirect_valid) begin
      id_valid  <= 1'b0;
      id_instr  <= NOP_INSTR;
      buf_valid <= 1'b0;
    end else if (rsp_take) begin
      // buf_valid is always 0 here: no request can be outstanding while it is set.
      if (!id_valid || !stall) begin
        id_valid <= 1'b1;
        id_instr <= imem_rsp_data;
        id_pc    <= req_pc;
      end else begin
        buf_valid <= 1'b1;
        buf_instr <= imem_rsp_data;
        buf_pc    <= req_pc;
      end
    end else if (!stall && buf_valid) begin
      id_valid  <= 1'b1;
      id_instr  <= buf_instr;
      id_pc     <= buf_pc;
      buf_valid <= 1'b0;
    end else if (!stall && id_valid) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count responses kept versus responses thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (rsp_take) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (rsp_drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`else
  // rsp_drop only feeds the optional counters.
  logic unused_drop;
  assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, asynchronous reset check,
// then randomized traffic against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DA  = 32'h002081B3;
  localparam logic [31:0] DB  = 32'h00308233;
  localparam logic [31:0] DC  = 32'h004102B3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_opcode(id_opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st, rd;
    logic [31:0] rp;
    logic        rdy, rv;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  function automatic vec_t mk(input logic st, rd, input logic [31:0] rp,
                              input logic rdy, rv, input logic [31:0] rdat,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, ep);
    vec_t v;
    v.st = st; v.rd = rd; v.rp = rp; v.rdy = rdy; v.rv = rv; v.rdat = rdat;
    v.e_req = er; v.e_addr = ea; v.e_idv = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        m_q[$];       // head = ID register, second entry = skid buffer
  logic [31:0] m_pc, m_req_pc, m_idpc, m_fetch, m_drops;
  bit          m_out, m_drop;

  // Memory environment
  bit          mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic bit m_req_valid();
    return !m_out && (m_q.size() < 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc = '0; m_req_pc = '0; m_idpc = '0; m_fetch = '0; m_drops = '0;
    m_out = 0; m_drop = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  task automatic model_step(input bit st, rd, input logic [31:0] rp, input bit rdy,
                            input bit rv, input logic [31:0] rdat);
    bit   hs, deliver;
    ent_t e;
    hs = m_req_valid() && rdy;
    deliver = 0;
    if (rv && m_out) begin
      if (m_drop || rd) m_drops++;
      else deliver = 1;
      m_out = 0;
    end
    if (!rd) begin
      if (!st && m_q.size() > 0) void'(m_q.pop_front());
      if (deliver) begin
        e.instr = rdat; e.pc = m_req_pc;
        m_q.push_back(e);
        m_fetch++;
      end
    end
    if (hs) begin
      m_out = 1; m_drop = 0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      m_q.delete();
      m_pc = {rp[31:2], 2'b00};
      if (m_out) m_drop = 1;
    end
    if (m_q.size() > 0) m_idpc = m_q[0].pc;
  endtask

  task automatic check_model();
    logic [31:0] ei;
    ei = (m_q.size() > 0) ? m_q[0].instr : NOP;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, m_req_valid()});
    chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_q.size() > 0});
    chk("id_instr", id_instr, ei);
    chk("id_pc", id_pc, m_idpc);
    chk("id_opcode", {25'd0, id_opcode}, {25'd0, ei[6:0]});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetch);
    chk("perf_drop", perf_drop_cnt, m_drops);
`endif
  endtask

  task automatic step_rand();
    bit          hs_dut;
    logic [31:0] a_dut;
    @(negedge clk);
    stall          = ($urandom_range(0, 9) < 3);
    redirect_valid = ($urandom_range(0, 19) == 0);
    redirect_pc    = $urandom;
    imem_req_ready = ($urandom_range(0, 9) < 7);
    imem_rsp_valid = mem_busy && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    #1;
    hs_dut = imem_req_valid && imem_req_ready;
    a_dut  = imem_req_addr;
    model_step(stall, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data);
    @(posedge clk);
    if (imem_rsp_valid) mem_busy = 0;
    if (hs_dut) begin
      mem_busy = 1; mem_addr = a_dut; mem_cnt = $urandom_range(0, 2);
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'd0);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_id_instr"}, id_instr, NOP);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_drop"}, perf_drop_cnt, 32'd0);
`endif
  endtask

  vec_t vt[24];

  initial begin
    vt[0]  = mk(0,0,32'h0,  1,0,32'h0, 0,32'h004,0,NOP,32'h000);
    vt[1]  = mk(0,0,32'h0,  0,1,DA,    1,32'h004,1,DA, 32'h000);
    vt[2]  = mk(0,0,32'h0,  1,0,32'h0, 0,32'h008,0,NOP,32'h000);
    vt[3]  = mk(0,0,32'h0,  0,1,DB,    1,32'h008,1,DB, 32'h004);
    vt[4]  = mk(0,0,32'h0,  1,0,32'h0, 0,32'h00C,0,NOP,32'h004);
    vt[5]  = mk(0,0,32'h0,  0,1,DC,    1,32'h00C,1,DC, 32'h008);
    vt[6]  = mk(1,0,32'h0,  1,0,32'h0, 0,32'h010,1,DC, 32'h008);
    vt[7]  = mk(1,0,32'h0,  0,1,DA,    0,32'h010,1,DC, 32'h008);
    vt[8]  = mk(1,0,32'h0,  1,0,32'h0, 0,32'h010,1,DC, 32'h008);
    vt[9]  = mk(0,0,32'h0,  0,0,32'h0, 1,32'h010,1,DA, 32'h00C);
    vt[10] = mk(0,0,32'h0,  1,0,32'h0, 0,32'h014,0,NOP,32'h00C);
    vt[11] = mk(0,1,32'h103,0,0,32'h0, 0,32'h100,0,NOP,32'h00C);
    vt[12] = mk(0,0,32'h0,  0,1,DB,    1,32'h100,0,NOP,32'h00C);
    vt[13] = mk(0,0,32'h0,  1,0,32'h0, 0,32'h104,0,NOP,32'h00C);
    vt[14] = mk(0,0,32'h0,  0,1,DC,    1,32'h104,1,DC, 32'h100);
    vt[15] = mk(0,0,32'h0,  1,0,32'h0, 0,32'h108,0,NOP,32'h100);
    vt[16] = mk(0,1,32'h200,0,1,DA,    1,32'h200,0,NOP,32'h100);
    vt[17] = mk(0,0,32'h0,  1,0,32'h0, 0,32'h204,0,NOP,32'h100);
    vt[18] = mk(0,0,32'h0,  0,1,DB,    1,32'h204,1,DB, 32'h200);
    vt[19] = mk(0,1,32'h302,1,0,32'h0, 0,32'h300,0,NOP,32'h200);
    vt[20] = mk(0,0,32'h0,  0,1,DA,    1,32'h300,0,NOP,32'h200);
    vt[21] = mk(1,0,32'h0,  0,0,32'h0, 1,32'h300,0,NOP,32'h200);
    vt[22] = mk(1,0,32'h0,  1,0,32'h0, 0,32'h304,0,NOP,32'h200);
    vt[23] = mk(1,0,32'h0,  0,1,DC,    1,32'h304,1,DC, 32'h300);

    // Reset held
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'd0);

    // Directed table
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      stall          = vt[i].st;
      redirect_valid = vt[i].rd;
      redirect_pc    = vt[i].rp;
      imem_req_ready = vt[i].rdy;
      imem_rsp_valid = vt[i].rv;
      imem_rsp_data  = vt[i].rdat;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, {31'd0, vt[i].e_idv});
      chk($sformatf("v%0d_id_instr", i), id_instr, vt[i].e_instr);
      chk($sformatf("v%0d_id_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("v%0d_id_opcode", i), {25'd0, id_opcode}, {25'd0, vt[i].e_instr[6:0]});
    end
`ifdef FETCH_PERF_CNT_EN
    chk("tbl_perf_fetch", perf_fetch_cnt, 32'd7);
    chk("tbl_perf_drop", perf_drop_cnt, 32'd3);
`endif

    // Asynchronous reset while waiting for a response
    @(negedge clk);
    stall = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("wait_id_valid", {31'd0, id_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    imem_req_ready = 1'b0;
    stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rel_req_addr", imem_req_addr, 32'd0);

    // Randomized traffic against the reference model
    model_reset();
    for (int c = 0; c < 3000; c++) step_rand();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of control_unit.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with an always-accepted response channel.
- Delivers fetched instruction, its PC and opcode (instr[6:0]) to decode.
- Honours decode stalls (one-entry skid buffer) and branch/jump redirects (flush plus discard of in-flight response).

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented in id_instr while empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; no backpressure, must be consumed.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  taken branch/jump from later stage.
- redirect_pc  in  XLEN  redirect target.
- stall  in  1  decode cannot accept a new instruction this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  32  registered instruction.
- id_pc  out  XLEN  PC of id_instr.
- id_opcode  out  7  id_instr[6:0], combinational from register.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=S_REQ, id_valid=0, id_instr=NOP_INSTR, id_pc=0, buf_valid=0.
  - imem_req_valid=0 while rst_n=0.
- FSM, at most one outstanding request:
  - S_REQ: imem_req_valid = !buf_valid. On handshake (valid&ready): pc<=pc+4 (mod 2^XLEN), go S_WAIT.
  - S_WAIT: imem_req_valid=0; on imem_rsp_valid deliver the response, go S_REQ.
  - S_DROP: imem_req_valid=0; on imem_rsp_valid discard data, go S_REQ.
- Response latency from memory is >=1 cycle after the handshake. Back-to-back issue: the request may assert in the cycle after the response returns.
- Delivery of an accepted response (S_WAIT):
  - If !id_valid || !stall: id_instr<=data, id_pc<=request pc, id_valid<=1.
  - Else: capture into skid buffer (buf_instr, buf_pc), buf_valid<=1.
- Decode consumption:
  - When stall=0 and id_valid=1 and the register is not reloaded this cycle: id_valid<=0, id_instr<=NOP_INSTR.
  - When stall=0 and buf_valid=1: buffer moves into the ID register, buf_valid<=0.
  - No request is issued while buf_valid=1, so the buffer can never overflow.
- Redirect (highest priority; overrides stall and delivery):
  - pc<=redirect_pc with bits [1:0] forced to 0; id_valid<=0, id_instr<=NOP_INSTR, buf_valid<=0.
  - In S_WAIT without a response this cycle, or with a request handshake this same cycle: go S_DROP.
  - In S_WAIT with a response this cycle: discard it, go S_REQ.
  - In S_DROP: stay S_DROP (pc updated).
  - In S_REQ without handshake: stay S_REQ.
- Stall with id_valid=0: the next response loads ID directly; stall only blocks consumption.
- imem_req_addr is always valid; low two bits are always 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_drop_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments per response delivered to ID or buffer.
  - perf_drop_cnt increments per response discarded (S_DROP or same-cycle redirect).
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, ready=1, memory returns data 1 cycle after each handshake -> addresses 0x0,0x4,0x8 issued; id_pc follows 0x0,0x4,0x8; id_opcode=7'b0110011 for data 32'h002081B3.
- stall=1 with id_valid=1, response arrives -> id holds old instruction, buf_valid=1, imem_req_valid=0. Drop stall -> next cycle id_instr=buffered word, requests resume.
- redirect_valid=1, redirect_pc=32'h0000_0103, while in S_WAIT -> next request address 0x100; the late response is discarded; id_valid=0 with id_instr=32'h0000_0013 until the 0x100 word arrives.
- redirect in the same cycle as a response -> response discarded, next request at the target, no extra drop.
- Assert rst_n=0 mid-S_WAIT -> outputs return immediately (asynchronously) to reset values; after release first request at RESET_PC.
- With FETCH_PERF_CNT_EN: 3 delivered plus 1 dropped response -> perf_fetch_cnt=3, perf_drop_cnt=1.
